// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: line configuration, encodings and receiver states.
package uart_pkg;

    localparam int unsigned OversampleDefault = 16;

    typedef enum logic [1:0] {
        Dw5Bit = 2'd0,
        Dw6Bit = 2'd1,
        Dw7Bit = 2'd2,
        Dw8Bit = 2'd3
    } data_width_e;

    typedef enum logic [1:0] {
        ParityEven      = 2'd0,
        ParityOdd       = 2'd1,
        ParityDisabled1 = 2'd2,
        ParityDisabled2 = 2'd3
    } parity_e;

    // Encodings 2 and 3 are reserved and behave as a single stop bit.
    typedef enum logic [1:0] {
        Stop1Bit  = 2'd0,
        Stop2Bit  = 2'd1,
        StopRsvd2 = 2'd2,
        StopRsvd3 = 2'd3
    } stop_bits_e;

    typedef struct packed {
        data_width_e data_width;
        parity_e     parity_mode;
        stop_bits_e  stop_bits;
    } uart_config_s;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StDone   = 3'd5
    } rx_fsm_e;

    function automatic logic parity_enabled(input parity_e mode);
        return (mode == ParityEven) || (mode == ParityOdd);
    endfunction

    // Index of the last data bit (bit counter value) for a given width.
    function automatic logic [2:0] last_data_bit(input data_width_e dw);
        return 3'd4 + {1'b0, dw};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level; reset value is configurable.
module sync_ff #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    generate
        if (Stages == 1) begin : g_single
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= ResetVal;
                end else begin
                    sync_q <= d_i;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= {Stages{ResetVal}};
                end else begin
                    sync_q <= {sync_q[Stages-2:0], d_i};
                end
            end
        end
    endgenerate

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: start-bit validation, 5-8 data bits LSB first,
// optional parity capture, 1/2 stop bits, and a one-cycle completion strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OversampleDefault,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ov_tick_i,
    input  logic         rx_i,
    input  uart_config_s config_i,
    input  logic         rx_fifo_full_i,
    output logic [7:0]   data_rx_o,
    output logic         parity_o,
    output logic         frame_error_o,
    output logic         overrun_o,
    output logic         rx_done_o,
    output logic         rx_fifo_write_o,
    output logic         busy_o
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    // The detection tick is tick 0, so the start-bit centre is reached when the
    // counter reads OVERSAMPLE/2 - 2 on the next tick.
    localparam logic [TickW-1:0] TickStartCentre = TickW'(OVERSAMPLE / 2 - 2);
    localparam logic [TickW-1:0] TickLast        = TickW'(OVERSAMPLE - 1);

    logic rx_s;

    sync_ff #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b1)
    ) u_rx_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    rx_fsm_e      state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]   bit_q, bit_d;
    logic         stop_q, stop_d;
    logic         armed_q, armed_d;
    uart_config_s cfg_q, cfg_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic         ferr_q, ferr_d;
    logic [7:0]   data_out_q, data_out_d;
    logic         par_out_q, par_out_d;
    logic         ferr_out_q, ferr_out_d;

    logic       centre;
    logic [7:0] shifted;

    assign centre  = ov_tick_i && (tick_q == TickLast);
    assign shifted = {rx_s, shift_q[7:1]};

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        armed_d    = armed_q;
        cfg_d      = cfg_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        data_out_d = data_out_q;
        par_out_d  = par_out_q;
        ferr_out_d = ferr_out_q;

        unique case (state_q)
            StIdle: begin
                if (ov_tick_i) begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                        armed_d = 1'b0;
                        cfg_d   = config_i;
                        shift_d = '0;
                        par_d   = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end

            StStart: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == TickStartCentre) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = StData;
                            bit_d   = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end

            StData: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + 1'b1;
                end
                if (centre) begin
                    shift_d = shifted;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == last_data_bit(cfg_q.data_width)) begin
                        // Bits arrive at the MSB end; right-justify with zero fill.
                        shift_d = shifted >> (3'd3 - {1'b0, cfg_q.data_width});
                        stop_d  = 1'b0;
                        state_d = parity_enabled(cfg_q.parity_mode) ? StParity : StStop;
                    end
                end
            end

            StParity: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + 1'b1;
                end
                if (centre) begin
                    par_d   = rx_s;
                    state_d = StStop;
                end
            end

            StStop: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + 1'b1;
                end
                if (centre) begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if ((cfg_q.stop_bits == Stop2Bit) && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d    = StDone;
                        data_out_d = shift_q;
                        par_out_d  = par_q;
                        ferr_out_d = ferr_q | ~rx_s;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
                armed_d = 1'b0;
            end

            default: begin
                state_d = StIdle;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            armed_q    <= 1'b0;
            cfg_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= '0;
            par_out_q  <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            armed_q    <= armed_d;
            cfg_q      <= cfg_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            data_out_q <= data_out_d;
            par_out_q  <= par_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    assign rx_done_o       = (state_q == StDone);
    assign overrun_o       = rx_done_o & rx_fifo_full_i;
    assign rx_fifo_write_o = rx_done_o & ~rx_fifo_full_i;
    assign busy_o          = (state_q != StIdle);
    assign data_rx_o       = data_out_q;
    assign parity_o        = par_out_q;
    assign frame_error_o   = ferr_out_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit by bit on a 4-clk tick grid.
module tb_uart_receiver;
    import uart_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ov_tick = 1'b0;
    logic         rx = 1'b1;
    logic         fifo_full = 1'b0;
    uart_config_s cfg;
    logic [7:0]   data_rx;
    logic         parity, frame_error, overrun, rx_done, fifo_write, busy;

    uart_receiver #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ov_tick_i       (ov_tick),
        .rx_i            (rx),
        .config_i        (cfg),
        .rx_fifo_full_i  (fifo_full),
        .data_rx_o       (data_rx),
        .parity_o        (parity),
        .frame_error_o   (frame_error),
        .overrun_o       (overrun),
        .rx_done_o       (rx_done),
        .rx_fifo_write_o (fifo_write),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int unsigned tick_div = 0;
    always @(posedge clk) begin
        tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
        ov_tick  <= (tick_div == 3);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: captures the frame payload while rx_done is high.
    int         done_cnt = 0;
    logic       prev_done = 1'b0;
    logic [7:0] cap_data = '0;
    logic       cap_par = 1'b0, cap_ferr = 1'b0, cap_ovr = 1'b0, cap_wr = 1'b0;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            cap_data = data_rx;
            cap_par  = parity;
            cap_ferr = frame_error;
            cap_ovr  = overrun;
            cap_wr   = fifo_write;
            check("no_back_to_back_strobe", {31'd0, prev_done}, 32'd0);
        end
        prev_done = rx_done;
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk iff ov_tick);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input int nstop, input logic stop2);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (par >= 0) send_bit(par[0]);
        send_bit(1'b1);
        if (nstop == 2) send_bit(stop2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        cfg = '{data_width: Dw8Bit, parity_mode: ParityDisabled1, stop_bits: Stop1Bit};
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", {24'd0, data_rx}, 32'h0);
        check("reset_flags", {26'd0, parity, frame_error, overrun, rx_done, fifo_write, busy},
              32'h0);
        send_idle(4);

        // 8N1 0xA5
        base = done_cnt;
        send_frame(8'hA5, 8, -1, 1, 1'b1);
        send_idle(4);
        check("8n1_count", done_cnt, base + 1);
        check("8n1_data", {24'd0, cap_data}, 32'hA5);
        check("8n1_parity", {31'd0, cap_par}, 32'd0);
        check("8n1_ferr", {31'd0, cap_ferr}, 32'd0);
        check("8n1_write", {31'd0, cap_wr}, 32'd1);
        check("8n1_overrun", {31'd0, cap_ovr}, 32'd0);

        // 5E1 10101 with parity bit 1
        cfg = '{data_width: Dw5Bit, parity_mode: ParityEven, stop_bits: Stop1Bit};
        base = done_cnt;
        send_frame(8'h15, 5, 1, 1, 1'b1);
        send_idle(4);
        check("5e1_count", done_cnt, base + 1);
        check("5e1_data", {24'd0, cap_data}, 32'h15);
        check("5e1_parity", {31'd0, cap_par}, 32'd1);
        check("5e1_ferr", {31'd0, cap_ferr}, 32'd0);

        // Start-bit glitch, then a valid frame
        cfg = '{data_width: Dw8Bit, parity_mode: ParityDisabled1, stop_bits: Stop1Bit};
        base = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        wait_ticks(1);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_no_strobe", done_cnt, base);
        send_idle(4);
        send_frame(8'h3C, 8, -1, 1, 1'b1);
        send_idle(4);
        check("after_glitch_count", done_cnt, base + 1);
        check("after_glitch_data", {24'd0, cap_data}, 32'h3C);

        // 8N2 with a bad second stop bit, then the line stuck low
        cfg = '{data_width: Dw8Bit, parity_mode: ParityDisabled2, stop_bits: Stop2Bit};
        base = done_cnt;
        send_frame(8'h0F, 8, -1, 2, 1'b0);
        wait_ticks(40 * 16);
        check("8n2_count", done_cnt, base + 1);
        check("8n2_data", {24'd0, cap_data}, 32'h0F);
        check("8n2_ferr", {31'd0, cap_ferr}, 32'd1);
        check("8n2_held_frame_error", {31'd0, frame_error}, 32'd1);
        check("stuck_low_idle", {31'd0, busy}, 32'd0);
        send_idle(32);
        check("stuck_low_no_strobe", done_cnt, base + 1);

        // Overrun: FIFO full at completion
        cfg = '{data_width: Dw8Bit, parity_mode: ParityDisabled1, stop_bits: Stop1Bit};
        base = done_cnt;
        @(negedge clk);
        fifo_full = 1'b1;
        send_frame(8'h55, 8, -1, 1, 1'b1);
        send_idle(4);
        fifo_full = 1'b0;
        check("ovr_count", done_cnt, base + 1);
        check("ovr_data", {24'd0, cap_data}, 32'h55);
        check("ovr_overrun", {31'd0, cap_ovr}, 32'd1);
        check("ovr_write", {31'd0, cap_wr}, 32'd0);

        // Reset during bit 3 of a frame, then a clean frame
        base = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", {24'd0, data_rx}, 32'h0);
        check("midrst_flags", {26'd0, parity, frame_error, overrun, rx_done, fifo_write, busy},
              32'h0);
        wait_ticks(8);
        send_idle(16 * 7);
        check("midrst_no_strobe", done_cnt, base);
        send_frame(8'hC3, 8, -1, 1, 1'b1);
        send_idle(4);
        check("after_rst_count", done_cnt, base + 1);
        check("after_rst_data", {24'd0, cap_data}, 32'hC3);
        check("after_rst_ferr", {31'd0, cap_ferr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage directly upstream of the main controller. Oversamples the asynchronous RX line at 16x baud and detects and validates the start bit. Deserialises 5–8 data bits LSB first, captures the parity bit and checks the stop bit(s). Presents each frame as a one-cycle strobe carrying data, received parity bit, frame error and overrun, which the main controller consumes for parity checking, error reporting and FIFO writes.

## Interface
Parameters:
- OVERSAMPLE, 16: baud ticks per bit; must be a power of two, ≥ 8.
- SYNC_STAGES, 2: flops in the RX line synchroniser.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ov_tick_i  in  1  one-cycle pulse from baud generator, OVERSAMPLE per bit period.
- rx_i  in  1  asynchronous serial line; idle high.
- config_i  in  uart_config_s  data_width / parity_mode / stop_bits.
- rx_fifo_full_i  in  1  RX FIFO full.
- data_rx_o  out  8  received data, zero-extended above data width.
- parity_o  out  1  received parity bit; 0 when parity disabled.
- frame_error_o  out  1  any sampled stop bit was 0.
- overrun_o  out  1  frame completed while rx_fifo_full_i high.
- rx_done_o  out  1  one-cycle frame-complete strobe.
- rx_fifo_write_o  out  1  equals rx_done_o & !rx_fifo_full_i.
- busy_o  out  1  high in every state except IDLE.

## Operation
States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: synchronised line (rx_s) is sampled only on ov_tick_i.
  - The receiver arms only after at least one tick with rx_s = 1. This prevents a held-low line from retriggering.
  - Armed and rx_s = 0 on a tick → START; tick counter cleared.
  - config_i is latched into an internal register on this transition. Changes during a frame are ignored.
- START: counts ticks to OVERSAMPLE/2 − 1 (bit centre).
  - rx_s = 0 at centre → DATA; tick counter and bit counter cleared.
  - rx_s = 1 at centre → glitch; return to IDLE with no strobe.
- DATA: samples every OVERSAMPLE ticks at bit centre and shifts right into an 8-bit register, LSB first.
  - After (5 + data_width) bits → PARITY if parity is EVEN/ODD, else STOP.
  - On exit, data is right-justified and zero-filled above the data width.
- PARITY: samples one bit into the parity register → STOP.
- STOP: samples one stop bit, or two if stop_bits = 2-bit encoding. Reserved encodings are treated as 1 stop bit.
  - Any stop sample = 0 sets the frame-error flag.
  - After the last stop sample → DONE.
- DONE: lasts exactly one clk.
  - rx_done_o = 1; data_rx_o, parity_o and frame_error_o are updated.
  - overrun_o = rx_fifo_full_i.
  - Next state is IDLE (disarmed until the line is seen high).
- A frame error does not suppress the strobe. Data is still delivered; the controller decides.
- The receiver does not check parity; it reports the received bit only.

## Timing
- Reset values: all outputs 0; state IDLE, disarmed; synchroniser flops reset to 1.
- Sampling point: tick OVERSAMPLE/2 − 1 of each bit, counted from the falling-edge detection tick.
- Latency: rx_done_o rises on the clk after the ov_tick_i that samples the last stop bit.
- data_rx_o, parity_o and frame_error_o hold their values until the next DONE.
- overrun_o and rx_fifo_write_o are valid only during rx_done_o.
- rx_i to rx_s delay is SYNC_STAGES clk. This is not compensated; it is negligible versus a tick period.
- Reset mid-frame: the next cycle is IDLE, disarmed, outputs 0, and no strobe is emitted. The partial frame is lost.
- rx_done_o never asserts on consecutive cycles. The minimum spacing is one full frame.
- Ticks arriving in DONE are ignored.

## Structure
- UART_pkg holds:
  - uart_config_s and encodings: DW_5BIT..DW_8BIT, EVEN/ODD/DISABLED_1/DISABLED_2, stop-bit encodings.
  - rx_fsm_e, the receiver state enum.
  - OVERSAMPLE_DEFAULT.
- Sub-module sync_ff (SYNC_STAGES-deep, reset value 1) synchronises rx_i. It is reusable for CTS/RTS.
- Counters:
  - tick counter: $clog2(OVERSAMPLE) bits, wraps naturally.
  - bit counter: 3 bits.
  - stop counter: 1 bit.

## Test plan
- 8N1, 0xA5, 16 ticks/bit → one rx_done_o; data_rx_o = 0xA5, parity_o = 0, frame_error_o = 0, rx_fifo_write_o = 1.
- 5-bit, EVEN, 1 stop, bits 10101 then parity 1 → data_rx_o = 0x15, parity_o = 1, frame_error_o = 0.
- Start-bit glitch: line low for 4 ticks then high → no rx_done_o, busy_o returns to 0. A subsequent valid 0x3C frame is received correctly.
- 8N2, 0x0F, second stop bit driven 0 → data_rx_o = 0x0F, frame_error_o = 1. Line then held low for 40 bits → no further strobe until the line returns high.
- 8N1, 0x55 with rx_fifo_full_i = 1 at completion → rx_done_o = 1, overrun_o = 1, rx_fifo_write_o = 0.
- rst_i pulsed during bit 3 of a frame → no strobe, all outputs 0 next cycle. A following 0xC3 frame is received correctly.
